// File: rtl/hpm_counter_bank_if.sv
// hpm_counter_bank_if: CSR access port of the HPM counter bank (address, write strobe/data, read data, access exception).
interface hpm_counter_bank_if #(
  parameter int XLEN = 64
) ();
  logic [11:0]     addr;
  logic            we;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            access_exc;
  modport master (output addr, we, wdata, input rdata, access_exc);
  modport slave  (input addr, we, wdata, output rdata, access_exc);
endinterface

// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: mhpmcounter/mhpmevent bank with multi-bit per-cycle increments.
// Define HPM_OVF_IRQ_EN to add sticky overflow flags and the counter-overflow interrupt.
module hpm_counter_bank #(
  parameter int NUM_COUNTERS = 6,
  parameter int CNT_WIDTH    = 64,
  parameter int XLEN         = 64,
  parameter int NUM_EVENTS   = 32,
  parameter int NUM_PORTS    = 2,
  localparam int EVT_W = $clog2(NUM_EVENTS),
  localparam int INC_W = $clog2(NUM_PORTS + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               debug_mode_i,
  input  logic [NUM_COUNTERS-1:0]            inhibit_i,
  input  logic [NUM_EVENTS-1:0][INC_W-1:0]   event_inc_i,
  hpm_counter_bank_if.slave                  csr,
  output logic                               ovf_irq_o
);
  // Every window base ends in 5'b00011, so addr-3 gives the index; low addresses wrap to 29..31 and miss.
  logic [4:0] idx;
  logic       in_rng, hit_cl, hit_ch, hit_ev, hit_ul, hit_uh;
  assign idx    = csr.addr[4:0] - 5'd3;
  assign in_rng = idx < 5'(NUM_COUNTERS);
  assign hit_cl = in_rng && csr.addr[11:5] == 7'h58;
  assign hit_ch = in_rng && csr.addr[11:5] == 7'h5C;
  assign hit_ev = in_rng && csr.addr[11:5] == 7'h19;
  assign hit_ul = in_rng && csr.addr[11:5] == 7'h60;
  assign hit_uh = in_rng && csr.addr[11:5] == 7'h64;
  logic [63:0]      cnt_q [32];
  logic [EVT_W-1:0] sel_q [32];
  logic [31:0]      of_q;
  logic [63:0]      wd64, rd_cnt;
  logic [XLEN-1:0]  rd_evt;
  assign wd64   = 64'(csr.wdata);
  assign rd_cnt = cnt_q[idx];
  assign rd_evt = XLEN'(sel_q[idx]) | (XLEN'(of_q[idx]) << (XLEN - 1));
  always_comb begin
    csr.rdata      = (hit_cl || hit_ul) ? XLEN'(rd_cnt) :
                     (XLEN == 32 && (hit_ch || hit_uh)) ? XLEN'(rd_cnt >> 32) :
                     hit_ev ? rd_evt : '0;
    csr.access_exc = (csr.we && (hit_ul || hit_uh)) || (XLEN == 64 && (hit_ch || hit_uh));
  end
  assign ovf_irq_o = |of_q;
  for (genvar k = 0; k < 32; k++) begin : g_cnt
    if (k < NUM_COUNTERS) begin : g_on
      logic [CNT_WIDTH-1:0] c_q, sum;
      logic [EVT_W-1:0]     s_q;
      logic [INC_W-1:0]     inc;
      logic [63:0]          c64;
      logic                 wr_c, wr_h, wr_e, en;
      assign c64  = 64'(c_q);
      assign wr_c = csr.we && hit_cl && idx == 5'(k);
      assign wr_h = csr.we && hit_ch && idx == 5'(k) && XLEN == 32;
      assign wr_e = csr.we && hit_ev && idx == 5'(k);
      assign inc  = (s_q != '0 && 32'(s_q) < NUM_EVENTS) ? event_inc_i[s_q] : '0;
      assign en   = !debug_mode_i && !inhibit_i[k] && !wr_c && !wr_h;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          c_q <= '0;
          s_q <= '0;
        end else begin
          if (wr_c) c_q <= CNT_WIDTH'(XLEN == 32 ? {c64[63:32], wd64[31:0]} : wd64);
          else if (wr_h) c_q <= CNT_WIDTH'({wd64[31:0], c64[31:0]});
          else if (en) c_q <= sum;
          if (wr_e) s_q <= csr.wdata[EVT_W-1:0];
        end
      end
`ifdef HPM_OVF_IRQ_EN
      logic cy, o_q;
      assign {cy, sum} = {1'b0, c_q} + (CNT_WIDTH + 1)'(inc);
      // A hardware wrap in the same cycle wins over a software clear.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) o_q <= 1'b0;
        else o_q <= (en && cy) || (wr_e ? csr.wdata[XLEN-1] : o_q);
      end
      assign of_q[k] = o_q;
`else
      assign sum     = c_q + CNT_WIDTH'(inc);
      assign of_q[k] = 1'b0;
`endif
      assign cnt_q[k] = c64;
      assign sel_q[k] = s_q;
    end else begin : g_off
      assign cnt_q[k] = '0;
      assign sel_q[k] = '0;
      assign of_q[k]  = 1'b0;
    end
  end
endmodule

// File: tb/tb_hpm_counter_bank.sv
// tb_hpm_counter_bank: scoreboard bench for hpm_counter_bank at default parameters (XLEN=64, 6 counters).
module tb_hpm_counter_bank;
  logic clk = 0, rst_n = 0, dbg = 0, ovf;
  logic [5:0] inh = '0;
  logic [31:0][1:0] ev = '0;
  int total = 0, bad = 0;
  typedef struct {string tag; logic [63:0] d; logic e; logic irq;} exp_t;
  exp_t sb[$];
  logic [63:0] m_cnt [6];
  logic [4:0]  m_sel [6];
  logic        m_of  [6];
  always #5 clk = ~clk;
  hpm_counter_bank_if #(.XLEN(64)) bus ();
  hpm_counter_bank dut (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg), .inhibit_i(inh),
    .event_inc_i(ev), .csr(bus), .ovf_irq_o(ovf)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  function automatic void model_reset();
    for (int k = 0; k < 6; k++) begin
      m_cnt[k] = '0;
      m_sel[k] = '0;
      m_of[k]  = 1'b0;
    end
  endfunction
  function automatic void model_rd(input logic [11:0] a, input logic w, output logic [63:0] d, output logic e);
    d = '0;
    e = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (a == 12'hB03 + 12'(k) || a == 12'hC03 + 12'(k)) d = m_cnt[k];
      if (a == 12'h323 + 12'(k)) d = {m_of[k], 58'b0, m_sel[k]};
      if (a == 12'hB83 + 12'(k) || a == 12'hC83 + 12'(k)) e = 1'b1;
      if (w && a == 12'hC03 + 12'(k)) e = 1'b1;
    end
  endfunction
  task automatic cyc(input logic [11:0] a, input logic w = 0, input logic [63:0] d = '0, input string tag = "");
    exp_t x;
    logic [63:0] nc [6];
    logic [4:0]  ns [6];
    logic        no [6];
    logic [64:0] s;
    logic        set;
    bus.addr = a;
    bus.we = w;
    bus.wdata = d;
    model_rd(a, w, x.d, x.e);
    x.tag = tag;
    x.irq = 1'b0;
    for (int k = 0; k < 6; k++) x.irq = x.irq | m_of[k];
    if (tag != "") sb.push_back(x);
    @(negedge clk);
    if (tag != "") begin
      x = sb.pop_front();
      chk({x.tag, ".data"}, bus.rdata, x.d);
      chk({x.tag, ".exc"}, 64'(bus.access_exc), 64'(x.e));
      chk({x.tag, ".irq"}, 64'(ovf), 64'(x.irq));
    end
    for (int k = 0; k < 6; k++) begin
      set = 1'b0;
      nc[k] = m_cnt[k];
      ns[k] = m_sel[k];
      if (w && a == 12'hB03 + 12'(k)) nc[k] = d;
      else if (!dbg && !inh[k]) begin
        s = {1'b0, m_cnt[k]} + 65'(m_sel[k] != 0 ? ev[m_sel[k]] : 2'd0);
        nc[k] = s[63:0];
        set = s[64];
      end
      if (w && a == 12'h323 + 12'(k)) begin
        ns[k] = d[4:0];
        no[k] = set | d[63];
      end else no[k] = m_of[k] | set;
`ifndef HPM_OVF_IRQ_EN
      no[k] = 1'b0;
`endif
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      m_cnt[k] = nc[k];
      m_sel[k] = ns[k];
      m_of[k]  = no[k];
    end
  endtask
  initial begin
    logic [11:0] bases [5];
    bases = '{12'hB03, 12'hB83, 12'h323, 12'hC03, 12'hC83};
    bus.addr = '0;
    bus.we = 1'b0;
    bus.wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 6; i++) cyc(12'hB03 + 12'(i), 0, 0, "rst_cnt");
    cyc(12'h323, 0, 0, "rst_evt");
    cyc(12'h323, 1, 64'd5, "wsel3");
    ev[5] = 2'd2;
    repeat (10) cyc(12'h000);
    inh[0] = 1'b1;
    cyc(12'hB03, 0, 0, "cnt20");
    chk("cnt20_abs", bus.rdata, 64'd20);
    repeat (3) cyc(12'h000);
    cyc(12'hB03, 0, 0, "inhibit");
    inh[0] = 1'b0;
    dbg = 1'b1;
    repeat (3) cyc(12'h000);
    cyc(12'hB03, 0, 0, "debug");
    dbg = 1'b0;
    cyc(12'hB03, 1, '1, "wmax");
    cyc(12'hB03, 0, 0, "atmax");
    cyc(12'hB03, 0, 0, "wrapped");
    cyc(12'h323, 0, 0, "evt_of");
    cyc(12'h323, 1, 64'd5, "clr_of");
    cyc(12'h323, 0, 0, "evt_clr");
    cyc(12'h324, 1, 64'd5, "wsel4");
    cyc(12'hB04, 1, 64'h1234, "w4");
    cyc(12'hB04, 0, 0, "r4");
    cyc(12'hB03, 0, 0, "c3_kept");
    cyc(12'hB83, 0, 0, "hi64");
    cyc(12'hC83, 0, 0, "uhi64");
    cyc(12'hC03, 1, 64'h55, "walias");
    cyc(12'hC03, 0, 0, "alias");
    cyc(12'h325, 1, '1, "wsel_all");
    cyc(12'h325, 0, 0, "rsel_all");
    cyc(12'h325, 1, 64'd32, "wsel_wrap");
    ev = '1;
    repeat (3) cyc(12'h000);
    cyc(12'hB05, 0, 0, "sel0_idle");
    cyc(12'hB09, 0, 0, "oor_b09");
    cyc(12'hB02, 0, 0, "oor_b02");
    cyc(12'h329, 1, 64'd7, "oor_329");
    for (int n = 0; n < 300; n++) begin
      logic [11:0] a;
      for (int e = 0; e < 32; e++) ev[e] = 2'($urandom_range(0, 2));
      inh = 6'($urandom);
      dbg = ($urandom_range(0, 7) == 0);
      a = bases[$urandom_range(0, 4)] + 12'($urandom_range(0, 6));
      cyc(a, $urandom_range(0, 3) == 0, {$urandom, $urandom}, "rand");
    end
    dbg = 1'b0;
    inh = '0;
    bus.addr = 12'hB03;
    bus.we = 1'b0;
    #3 rst_n = 0;
    #1 chk("arst.data", bus.rdata, 64'd0);
    chk("arst.irq", 64'(ovf), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    cyc(12'h323, 1, 64'd5, "post_rst");
    repeat (2) cyc(12'h000);
    cyc(12'hB03, 0, 0, "post_cnt");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
